// File: rtl/ixc_uclk_pkg.sv
// ixc_uclk_pkg: shared types and constants for the user-clock monitor.
// Imported by the interface, synchroniser and monitor top.
package ixc_uclk_pkg;

  localparam int unsigned PERIOD_W_DFLT = 16;
  localparam int unsigned MATCH_W       = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    ACQUIRE = 2'd2,
    LOCKED  = 2'd3
  } mon_state_e;

endpackage

// File: rtl/ixc_uclk_if.sv
// ixc_uclk_if: pulse-train input, controls, strobes and status
// between a uclk source/consumer and the monitor.
interface ixc_uclk_if
  import ixc_uclk_pkg::*;
#(
  parameter int unsigned PERIOD_W = PERIOD_W_DFLT
);

  logic                uclk;
  logic                enable;
  logic                clr_lost;
  logic                uclk_rise;
  logic                uclk_fall;
  logic                locked;
  logic                lost;
  logic [PERIOD_W-1:0] period;
  logic [31:0]         rise_count;

  modport master (
    output uclk,
    output enable,
    output clr_lost,
    input  uclk_rise,
    input  uclk_fall,
    input  locked,
    input  lost,
    input  period,
    input  rise_count
  );

  modport slave (
    input  uclk,
    input  enable,
    input  clr_lost,
    output uclk_rise,
    output uclk_fall,
    output locked,
    output lost,
    output period,
    output rise_count
  );

endinterface

// File: rtl/ixc_uclk_sync.sv
// ixc_uclk_sync: brings uclk into the clk domain and emits
// registered single-cycle rise/fall strobes.
module ixc_uclk_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Strobes are registered so they land SYNC_STAGES+1 edges after uclk moves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q <= s;
      rise_q <= s & ~hist_q;
      fall_q <= ~s & hist_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ixc_uclk_monitor.sv
// ixc_uclk_monitor: measures the uclk period in clk cycles,
// tracks lock, and flags drift or stall as sticky loss.
module ixc_uclk_monitor
  import ixc_uclk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PERIOD_W    = PERIOD_W_DFLT,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned TOL         = 1,
  parameter int unsigned TIMEOUT     = 1024
) (
  input logic       clk,
  input logic       rst_n,
  ixc_uclk_if.slave bus
);

  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] TMO_V   = PERIOD_W'(TIMEOUT);
  localparam logic [PERIOD_W:0]   TOL_V   = (PERIOD_W+1)'(TOL);
  localparam logic [MATCH_W-1:0]  LOCK_V  = MATCH_W'(LOCK_COUNT);
  localparam logic [MATCH_W-1:0]  M_ONE   = MATCH_W'(1);

  logic rise;
  logic fall;

  ixc_uclk_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(bus.uclk),
    .rise_o (rise),
    .fall_o (fall)
  );

  mon_state_e          state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] ref_q, ref_d;
  logic                ref_vld_q, ref_vld_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                lost_q, lost_d;
  logic [31:0]         rc_q, rc_d;

  logic [PERIOD_W:0]   diff;
  logic [PERIOD_W:0]   mag;
  logic                in_tol;
  logic                stall;
  logic                lost_set;
  logic [MATCH_W-1:0]  match_inc;

  // One extra bit keeps the sign of cnt-ref; a saturated cnt never matches
  assign diff      = {1'b0, cnt_q} - {1'b0, ref_q};
  assign mag       = diff[PERIOD_W] ? -diff : diff;
  assign in_tol    = (cnt_q != CNT_MAX) && (mag <= TOL_V);
  assign stall     = (cnt_q >= TMO_V);
  assign match_inc = match_q + M_ONE;

  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q;
    ref_vld_d = ref_vld_q;
    match_d   = match_q;
    period_d  = period_q;
    lost_set  = 1'b0;
    rc_d      = rc_q + 32'(rise);

    if (rise) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    if (!bus.enable) begin
      state_d = IDLE;
      match_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARMED;
          match_d = '0;
        end
        ARMED: begin
          if (rise) begin
            state_d   = ACQUIRE;
            ref_vld_d = 1'b0;
            match_d   = '0;
          end
        end
        ACQUIRE: begin
          if (rise) begin
            period_d  = cnt_q;
            ref_d     = cnt_q;
            ref_vld_d = 1'b1;
            if (ref_vld_q && in_tol) begin
              match_d = match_inc;
              if (match_inc >= LOCK_V) begin
                state_d = LOCKED;
              end
            end else begin
              match_d = '0;
            end
          end else if (stall) begin
            state_d = ARMED;
            match_d = '0;
          end
        end
        LOCKED: begin
          if (rise) begin
            period_d = cnt_q;
            if (!in_tol) begin
              state_d  = ACQUIRE;
              lost_set = 1'b1;
              match_d  = '0;
              ref_d    = cnt_q;
            end
          end else if (stall) begin
            state_d  = ACQUIRE;
            lost_set = 1'b1;
            match_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (lost_set) begin
      lost_d = 1'b1;
    end else if (bus.clr_lost) begin
      lost_d = 1'b0;
    end else begin
      lost_d = lost_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ref_q     <= '0;
      ref_vld_q <= 1'b0;
      match_q   <= '0;
      period_q  <= '0;
      lost_q    <= 1'b0;
      rc_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_q     <= ref_d;
      ref_vld_q <= ref_vld_d;
      match_q   <= match_d;
      period_q  <= period_d;
      lost_q    <= lost_d;
      rc_q      <= rc_d;
    end
  end

  assign bus.uclk_rise  = rise;
  assign bus.uclk_fall  = fall;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.lost       = lost_q;
  assign bus.period     = period_q;
  assign bus.rise_count = rc_q;

endmodule

// File: tb/tb_ixc_uclk_monitor.sv
// tb_ixc_uclk_monitor: random and directed uclk trains checked
// cycle by cycle against a time-stamp based reference model.
module tb_ixc_uclk_monitor;

  localparam int S    = 2;
  localparam int W    = 16;
  localparam int LK   = 4;
  localparam int TOL  = 1;
  localparam int TMO  = 1024;
  localparam int CMAX = (1 << W) - 1;

  typedef enum int {M_OFF, M_WAIT, M_ACQ, M_LCK} mmode_e;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ixc_uclk_if #(.PERIOD_W(W)) bus ();

  ixc_uclk_monitor #(
    .SYNC_STAGES(S),
    .PERIOD_W   (W),
    .LOCK_COUNT (LK),
    .TOL        (TOL),
    .TIMEOUT    (TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  bit u_v   = 1'b0;
  bit en_v  = 1'b0;
  bit clr_v = 1'b0;

  bit          uh[$];
  bit          m_rise, m_fall, m_lost, m_ref_ok;
  int          m_now, m_last, m_ref, m_run, m_per;
  int unsigned m_rc;
  mmode_e      m_mode;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit close(int a, int b);
    int d;
    d = (a > b) ? a - b : b - a;
    return (a != CMAX) && (d <= TOL);
  endfunction

  function automatic void model_reset();
    uh = {};
    for (int i = 0; i < S + 2; i++) uh.push_back(1'b0);
    m_rise = 0; m_fall = 0; m_lost = 0; m_ref_ok = 0;
    m_now = 0; m_last = 0; m_ref = 0; m_run = 0; m_per = 0;
    m_rc = 0; m_mode = M_OFF;
  endfunction

  // cnt is derived from the time stamp of the last rise
  function automatic void model_step();
    int c;
    bit r, ls;
    c = m_now - m_last;
    if (c > CMAX) c = CMAX;
    r  = m_rise;
    ls = 1'b0;
    m_now++;
    uh.push_front(u_v);
    void'(uh.pop_back());
    m_rise = uh[S] && !uh[S+1];
    m_fall = !uh[S] && uh[S+1];
    if (r) begin
      m_rc++;
      m_last = m_now - 1;
    end
    if (!en_v) begin
      m_mode = M_OFF;
      m_run  = 0;
    end else begin
      case (m_mode)
        M_OFF: begin
          m_mode = M_WAIT;
          m_run  = 0;
        end
        M_WAIT: if (r) begin
          m_mode   = M_ACQ;
          m_ref_ok = 0;
          m_run    = 0;
        end
        M_ACQ: if (r) begin
          m_per    = c;
          m_run    = (m_ref_ok && close(c, m_ref)) ? m_run + 1 : 0;
          m_ref    = c;
          m_ref_ok = 1;
          if (m_run >= LK) m_mode = M_LCK;
        end else if (c >= TMO) begin
          m_mode = M_WAIT;
          m_run  = 0;
        end
        M_LCK: if (r) begin
          m_per = c;
          if (!close(c, m_ref)) begin
            m_mode = M_ACQ; ls = 1; m_run = 0; m_ref = c;
          end
        end else if (c >= TMO) begin
          m_mode = M_ACQ; ls = 1; m_run = 0;
        end
        default: m_mode = M_OFF;
      endcase
    end
    if (ls) m_lost = 1'b1;
    else if (clr_v) m_lost = 1'b0;
  endfunction

  task automatic cmp_all();
    chk("rise", 32'(bus.uclk_rise), 32'(m_rise));
    chk("fall", 32'(bus.uclk_fall), 32'(m_fall));
    chk("locked", 32'(bus.locked), 32'(m_mode == M_LCK));
    chk("lost", 32'(bus.lost), 32'(m_lost));
    chk("period", 32'(bus.period), 32'(m_per));
    chk("rise_count", bus.rise_count, m_rc);
  endtask

  task automatic tick();
    @(negedge clk);
    bus.uclk     = u_v;
    bus.enable   = en_v;
    bus.clr_lost = clr_v;
    @(posedge clk);
    #1;
    if (rst_n) begin
      model_step();
      cmp_all();
    end
  endtask

  task automatic train(int per, int n);
    for (int j = 0; j < n; j++)
      for (int c = 0; c < per; c++) begin
        u_v = (c < (per + 1) / 2);
        tick();
      end
  endtask

  task automatic clr_pulse();
    clr_v = 1'b1;
    tick();
    clr_v = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    bit r4[4];
    bus.uclk     = 1'b0;
    bus.enable   = 1'b0;
    bus.clr_lost = 1'b0;
    model_reset();
    repeat (3) tick();
    #2 rst_n = 1'b1;
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_lost", 32'(bus.lost), 32'd0);
    chk("rst_period", 32'(bus.period), 32'd0);
    chk("rst_rc", bus.rise_count, 32'd0);
    tick();

    // strobe latency and width, monitor disabled
    u_v = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); r4[i] = bus.uclk_rise; end
    chk("rise_lat0", 32'(r4[0]), 32'd0);
    chk("rise_lat1", 32'(r4[1]), 32'd0);
    chk("rise_lat2", 32'(r4[2]), 32'd1);
    chk("rise_lat3", 32'(r4[3]), 32'd0);
    u_v = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); r4[i] = bus.uclk_fall; end
    chk("fall_lat1", 32'(r4[1]), 32'd0);
    chk("fall_lat2", 32'(r4[2]), 32'd1);
    chk("fall_lat3", 32'(r4[3]), 32'd0);

    // steady 10-cycle train locks
    en_v = 1'b1;
    train(10, 8);
    chk("t1_locked", 32'(bus.locked), 32'd1);
    chk("t1_period", 32'(bus.period), 32'd10);

    // one 12-cycle period drifts out of tolerance
    train(12, 1);
    train(10, 1);
    chk("t3_locked", 32'(bus.locked), 32'd0);
    chk("t3_lost", 32'(bus.lost), 32'd1);
    clr_pulse();
    chk("t3_clr", 32'(bus.lost), 32'd0);

    // stall then relock
    train(10, 8);
    chk("t4_pre", 32'(bus.locked), 32'd1);
    u_v = 1'b0;
    repeat (TMO + 80) tick();
    chk("t4_locked", 32'(bus.locked), 32'd0);
    chk("t4_lost", 32'(bus.lost), 32'd1);
    train(10, 10);
    chk("t4_relock", 32'(bus.locked), 32'd1);
    clr_pulse();
    chk("t4_clr", 32'(bus.lost), 32'd0);

    // +/-1 jitter holds lock
    train(10, 1); train(11, 1); train(10, 1);
    train(11, 1); train(10, 1); train(10, 1);
    chk("t5_locked", 32'(bus.locked), 32'd1);
    chk("t5_lost", 32'(bus.lost), 32'd0);

    // randomized trains, clears and enable drops
    for (int k = 0; k < 40; k++) begin
      int base, n;
      base = $urandom_range(5, 16);
      n    = $urandom_range(2, 8);
      for (int j = 0; j < n; j++)
        train(base + $urandom_range(0, 2) - 1, 1);
      if ($urandom_range(0, 3) == 0) clr_pulse();
      if ($urandom_range(0, 9) == 0) begin
        en_v = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
        en_v = 1'b1;
      end
    end
    u_v = 1'b0;
    repeat (TMO + 20) tick();

    // disable keeps period
    en_v = 1'b1;
    train(10, 8);
    chk("t6_locked", 32'(bus.locked), 32'd1);
    en_v = 1'b0;
    repeat (3) tick();
    chk("t6_idle_locked", 32'(bus.locked), 32'd0);
    chk("t6_idle_period", 32'(bus.period), 32'd10);

    // async reset while locked
    en_v = 1'b1;
    train(10, 8);
    chk("t6_relock", 32'(bus.locked), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_locked", 32'(bus.locked), 32'd0);
    chk("arst_period", 32'(bus.period), 32'd0);
    chk("arst_rc", bus.rise_count, 32'd0);
    chk("arst_rise", 32'(bus.uclk_rise), 32'd0);
    model_reset();
    u_v  = 1'b0;
    en_v = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b1;
    tick();
    chk("rel_rise", 32'(bus.uclk_rise), 32'd0);
    en_v = 1'b1;
    train(10, 8);
    chk("rel_locked", 32'(bus.locked), 32'd1);
    chk("rel_rc", bus.rise_count, 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
